// File: rtl/sodor_imem_pkg.sv
// Shared types and constants for the Sodor instruction-memory responder.
package sodor_imem_pkg;

   localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
   localparam int unsigned MAX_LATENCY = 4;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic        fault;
   } imem_resp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// Stallable, flushable N-stage response pipeline; N=0 degenerates to a wire.
module imem_resp_pipe
   import sodor_imem_pkg::*;
#(
   parameter int unsigned N = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       flush,
   input  imem_resp_t in_ent,
   input  logic       out_ready,
   output logic       in_ready,
   output imem_resp_t out_ent
);

   generate
      if (N == 0) begin : g_comb
         assign in_ready = out_ready & ~flush;

         always_comb begin
            out_ent       = in_ent;
            out_ent.valid = in_ent.valid & ~flush;
         end
      end else begin : g_pipe
         imem_resp_t stage [N];
         logic       advance;

         // The whole pipe moves whenever the output slot is empty or being consumed.
         assign advance  = ~stage[N-1].valid | out_ready;
         assign in_ready = advance & ~flush;
         assign out_ent  = stage[N-1];

         always_ff @(posedge clock) begin
            if (reset || flush) begin
               for (int i = 0; i < int'(N); i++) begin
                  stage[i].valid <= 1'b0;
               end
            end else if (advance) begin
               for (int i = int'(N) - 1; i > 0; i--) begin
                  stage[i] <= stage[i-1];
               end
               stage[0].valid <= in_ent.valid & in_ready;
               stage[0].data  <= in_ent.data;
               stage[0].fault <= in_ent.fault;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/sodor_imem_responder.sv
// Memory side of the Sodor imem interface: loadable program store answering fetches after LATENCY cycles.
module sodor_imem_responder
   import sodor_imem_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned LATENCY  = 1,
   parameter logic [31:0] NOP_WORD = sodor_imem_pkg::NOP_WORD
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic              io_imem_req_valid,
   output logic              io_imem_req_ready,
   input  logic [31:0]       io_imem_req_bits_addr,
   output logic              io_imem_resp_valid,
   input  logic              io_imem_resp_ready,
   output logic [31:0]       io_imem_resp_bits_data,
   output logic              io_imem_resp_fault,
   input  logic              flush,
   output logic [31:0]       fetch_count
);

   localparam int unsigned PIPE_N = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

   logic [31:0]       store [DEPTH];
   logic [DEPTH-1:0]  written;
   logic [ADDR_W-1:0] index;
   logic              misaligned;
   logic              pipe_ready;
   imem_resp_t        lookup;
   imem_resp_t        pipe_out;
   logic              unused_addr_bits;

   assign index            = io_imem_req_bits_addr[ADDR_W+1:2];
   assign misaligned       = |io_imem_req_bits_addr[1:0];
   assign unused_addr_bits = ^io_imem_req_bits_addr[31:ADDR_W+2];

   // Data array carries no reset; the bitmap alone decides what reads as a NOP.
   always_ff @(posedge clock) begin
      if (load_en && !reset) begin
         store[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         written <= '0;
      end else if (load_en) begin
         written[load_addr] <= 1'b1;
      end
   end

   // Read sees the store before this edge's load, giving read-before-write.
   always_comb begin
      lookup.valid = io_imem_req_valid;
      lookup.fault = misaligned;
      lookup.data  = NOP_WORD;
      if (!misaligned && written[index]) begin
         lookup.data = store[index];
      end
   end

   imem_resp_pipe #(
      .N(PIPE_N)
   ) u_pipe (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .in_ent   (lookup),
      .out_ready(io_imem_resp_ready),
      .in_ready (pipe_ready),
      .out_ent  (pipe_out)
   );

   assign io_imem_req_ready      = pipe_ready & ~reset;
   assign io_imem_resp_valid     = pipe_out.valid & ~reset;
   assign io_imem_resp_fault     = pipe_out.fault & ~reset;
   assign io_imem_resp_bits_data = reset ? NOP_WORD : pipe_out.data;

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_count <= '0;
      end else if (io_imem_resp_valid && io_imem_resp_ready) begin
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_sodor_imem_responder.sv
// Bench for sodor_imem_responder: LATENCY 0/1/2 copies share stimulus and are checked against a slot-queue model.
module tb_sodor_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int unsigned ND  = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [31:0] load_data;
   logic        req_valid;
   logic [31:0] addr;
   logic        resp_ready;
   logic        flush;

   logic        rdy [ND];
   logic        rv  [ND];
   logic [31:0] rd  [ND];
   logic        rf  [ND];
   logic [31:0] cnt [ND];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      sodor_imem_responder #(
         .LATENCY(g)
      ) u_dut (
         .clock                 (clock),
         .reset                 (reset),
         .load_en               (load_en),
         .load_addr             (load_addr),
         .load_data             (load_data),
         .io_imem_req_valid     (req_valid),
         .io_imem_req_ready     (rdy[g]),
         .io_imem_req_bits_addr (addr),
         .io_imem_resp_valid    (rv[g]),
         .io_imem_resp_ready    (resp_ready),
         .io_imem_resp_bits_data(rd[g]),
         .io_imem_resp_fault    (rf[g]),
         .flush                 (flush),
         .fetch_count           (cnt[g])
      );
   end

   // Reference: per-copy array of LATENCY slots, slot L-1 is what the core sees.
   logic        mv   [ND][4];
   logic [31:0] md   [ND][4];
   logic        mf   [ND][4];
   logic [31:0] mcnt [ND];
   logic [31:0] mem  [16];
   logic        wr   [16];
   logic        e_rv  [ND];
   logic        e_rdy [ND];
   logic        e_adv [ND];
   logic [31:0] e_lw;
   logic        e_mis;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic settle_check();
      logic [3:0]  idx;
      logic [31:0] exp_d;
      logic        exp_f;
      @(negedge clock);
      e_mis = |addr[1:0];
      idx   = addr[5:2];
      e_lw  = (!e_mis && wr[idx] === 1'b1) ? mem[idx] : NOP;
      for (int d = 0; d < int'(ND); d++) begin
         if (d == 0) begin
            e_rv[d]  = req_valid & ~flush & ~reset;
            e_rdy[d] = resp_ready & ~flush & ~reset;
            e_adv[d] = 1'b1;
            exp_d    = reset ? NOP : e_lw;
            exp_f    = reset ? 1'b0 : e_mis;
         end else begin
            e_adv[d] = ~mv[d][d-1] | resp_ready;
            e_rv[d]  = mv[d][d-1] & ~reset;
            e_rdy[d] = e_adv[d] & ~flush & ~reset;
            exp_d    = reset ? NOP : md[d][d-1];
            exp_f    = reset ? 1'b0 : mf[d][d-1];
         end
         check_eq($sformatf("L%0d_req_ready", d), 32'(rdy[d]), 32'(e_rdy[d]));
         check_eq($sformatf("L%0d_resp_valid", d), 32'(rv[d]), 32'(e_rv[d]));
         if (e_rv[d] || reset) begin
            check_eq($sformatf("L%0d_resp_data", d), rd[d], exp_d);
            check_eq($sformatf("L%0d_resp_fault", d), 32'(rf[d]), 32'(exp_f));
         end
         check_eq($sformatf("L%0d_fetch_count", d), cnt[d], mcnt[d]);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      for (int d = 0; d < int'(ND); d++) begin
         if (reset) begin
            mcnt[d] = 32'd0;
            for (int s = 0; s < 4; s++) mv[d][s] = 1'b0;
         end else begin
            if (e_rv[d] && resp_ready) mcnt[d] = mcnt[d] + 32'd1;
            if (d > 0) begin
               if (flush) begin
                  for (int s = 0; s < 4; s++) mv[d][s] = 1'b0;
               end else if (e_adv[d]) begin
                  for (int s = d - 1; s > 0; s--) begin
                     mv[d][s] = mv[d][s-1];
                     md[d][s] = md[d][s-1];
                     mf[d][s] = mf[d][s-1];
                  end
                  mv[d][0] = req_valid & e_rdy[d];
                  md[d][0] = e_lw;
                  mf[d][0] = e_mis;
               end
            end
         end
      end
      if (reset) begin
         for (int i = 0; i < 16; i++) wr[i] = 1'b0;
      end else if (load_en) begin
         mem[load_addr] = load_data;
         wr[load_addr]  = 1'b1;
      end
      #1;
   endtask

   task automatic step();
      settle_check();
      tick();
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic rr);
      req_valid  = v;
      addr       = a;
      resp_ready = rr;
   endtask

   task automatic do_load(input logic [3:0] a, input logic [31:0] w);
      load_en   = 1'b1;
      load_addr = a;
      load_data = w;
      step();
      load_en   = 1'b0;
   endtask

   logic [31:0] saved [ND];

   initial begin
      for (int d = 0; d < int'(ND); d++) begin
         mcnt[d] = 32'd0;
         for (int s = 0; s < 4; s++) mv[d][s] = 1'b0;
      end
      for (int i = 0; i < 16; i++) wr[i] = 1'b0;
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      flush = 1'b0;
      drive(1'b0, 32'd0, 1'b1);
      step();
      step();
      reset = 1'b0;

      // Basic fetch of a loaded word.
      do_load(4'd1, 32'h0640_0083);
      drive(1'b1, 32'h4, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("t1_data", rd[1], 32'h0640_0083);
      check_eq("t1_valid", 32'(rv[1]), 32'd1);
      tick();
      check_eq("t1_count", cnt[1], 32'd1);

      // Unwritten word, address wrap, misaligned.
      drive(1'b1, 32'h0, 1'b1);
      step();
      drive(1'b1, 32'h44, 1'b1);
      settle_check();
      check_eq("unwritten_data", rd[1], NOP);
      tick();
      drive(1'b1, 32'h6, 1'b1);
      settle_check();
      check_eq("wrap_data", rd[1], 32'h0640_0083);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("misaligned_data", rd[1], NOP);
      check_eq("misaligned_fault", 32'(rf[1]), 32'd1);
      tick();

      // Backpressure on the two-stage copy.
      do_load(4'd3, 32'h0030_0093);
      do_load(4'd4, 32'h0040_0113);
      do_load(4'd5, 32'h0050_0193);
      step();
      step();
      saved[2] = cnt[2];
      drive(1'b1, 32'hC, 1'b0);
      step();
      drive(1'b1, 32'h10, 1'b0);
      step();
      drive(1'b1, 32'h14, 1'b0);
      settle_check();
      check_eq("bp_req_ready", 32'(rdy[2]), 32'd0);
      check_eq("bp_head_data", rd[2], 32'h0030_0093);
      tick();
      drive(1'b1, 32'h14, 1'b1);
      settle_check();
      check_eq("bp_hold_data", rd[2], 32'h0030_0093);
      tick();
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) step();
      check_eq("bp_count", cnt[2], saved[2] + 32'd3);

      // Flush discards in-flight responses.
      for (int d = 0; d < int'(ND); d++) saved[d] = cnt[d];
      drive(1'b1, 32'h4, 1'b0);
      step();
      drive(1'b1, 32'hC, 1'b0);
      step();
      flush = 1'b1;
      drive(1'b1, 32'h10, 1'b0);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("flush_valid_L1", 32'(rv[1]), 32'd0);
      check_eq("flush_valid_L2", 32'(rv[2]), 32'd0);
      tick();
      step();
      for (int d = 0; d < int'(ND); d++) check_eq($sformatf("flush_count_L%0d", d), cnt[d], saved[d]);
      drive(1'b1, 32'h4, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step();
      check_eq("post_flush_count_L2", cnt[2], saved[2] + 32'd1);

      // Same-cycle load and fetch returns the old word.
      do_load(4'd2, 32'h0020_0113);
      load_en = 1'b1; load_addr = 4'd2; load_data = 32'h0030_0193;
      drive(1'b1, 32'h8, 1'b1);
      settle_check();
      check_eq("rbw_data_L0", rd[0], 32'h0020_0113);
      tick();
      load_en = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("rbw_data_L1", rd[1], 32'h0020_0113);
      tick();

      // Reset mid-stream clears bitmap and count.
      drive(1'b1, 32'h8, 1'b1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("rst_valid_L2", 32'(rv[2]), 32'd0);
      check_eq("rst_count_L1", cnt[1], 32'd0);
      tick();
      drive(1'b1, 32'h8, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1);
      settle_check();
      check_eq("rst_reads_nop", rd[1], NOP);
      tick();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(7) != 0) a[1:0] = 2'b00;
         reset     = ($urandom_range(199) == 0);
         flush     = ($urandom_range(15) == 0);
         load_en   = ($urandom_range(3) == 0);
         load_addr = 4'($urandom);
         load_data = $urandom;
         drive(($urandom_range(3) != 0), a, ($urandom_range(2) != 0));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
